// File: rtl/hs_byte_packer_pkg.sv
// Shared defaults and types for the byte packer and other wide-side stages.
package hs_pkg;

   localparam int HS_DATA_W = 8;
   localparam int HS_PACK_N = 4;

   typedef logic [HS_PACK_N-1:0] keep_t;

   localparam keep_t KEEP_ALL = {HS_PACK_N{1'b1}};

endpackage

// File: rtl/hs_byte_packer_if.sv
// Narrow-in / wide-out handshake bundle for hs_byte_packer.
// slave = the packer itself, master = whatever drives the narrow side and sinks the wide side.
interface hs_byte_packer_if import hs_pkg::*; #(
   parameter int DATA_W = HS_DATA_W,
   parameter int PACK_N = HS_PACK_N
);

   logic                       valid_pre_i;
   logic [DATA_W-1:0]          data_pre_i;
   logic                       ready_pre_o;
   logic                       valid_post_o;
   logic [DATA_W*PACK_N-1:0]   data_post_o;
   logic [PACK_N-1:0]          keep_post_o;
   logic                       ready_post_i;
   logic                       flush_i;

   modport slave (
      input  valid_pre_i, data_pre_i, ready_post_i, flush_i,
      output ready_pre_o, valid_post_o, data_post_o, keep_post_o
   );

   modport master (
      output valid_pre_i, data_pre_i, ready_post_i, flush_i,
      input  ready_pre_o, valid_post_o, data_post_o, keep_post_o
   );

endinterface

// File: rtl/hs_byte_packer_out_slot.sv
// hs_out_slot: single-entry registered valid/ready output slot with word+keep payload.
// The owner must only pulse i_load while o_free is high, so a held word is never overwritten.
module hs_out_slot import hs_pkg::*; #(
   parameter int W  = HS_DATA_W*HS_PACK_N,
   parameter int KW = HS_PACK_N
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [W-1:0]  i_data,
   input  logic [KW-1:0] i_keep,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [W-1:0]  o_data,
   output logic [KW-1:0] o_keep,
   output logic          o_free
);

   logic          r_valid;
   logic [W-1:0]  r_data;
   logic [KW-1:0] r_keep;

   // Slot register: load replaces, handshake empties, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= {W{1'b0}};
         r_keep  <= {KW{1'b1}};
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_keep  <= i_keep;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_data  <= r_data;
         r_keep  <= r_keep;
      end else begin
         r_valid <= r_valid;
         r_data  <= r_data;
         r_keep  <= r_keep;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_keep  = r_keep;
   assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/hs_byte_packer.sv
// hs_byte_packer: packs PACK_N narrow beats little-endian into one wide registered word.
// Define PARTIAL_FLUSH_EN to enable flush_i emission of partially filled words.
module hs_byte_packer import hs_pkg::*; #(
   parameter int DATA_W = HS_DATA_W,
   parameter int PACK_N = HS_PACK_N
) (
   input logic            clk,
   input logic            rst_n,
   hs_byte_packer_if.slave hs
);

   localparam int OUT_W = DATA_W*PACK_N;
   localparam int ACC_W = OUT_W - DATA_W;
   localparam int CW    = (PACK_N > 2) ? $clog2(PACK_N) : 1;
   localparam int CEW   = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(PACK_N-1);

   logic [CW-1:0]    r_cnt;
   logic [ACC_W-1:0] r_acc;

   logic             w_flush_pend;
   logic             w_slot_free;
   logic             w_last;
   logic             w_ready;
   logic             w_fire;
   logic             w_full;
   logic             w_flush_req;
   logic             w_flush_go;
   logic             w_flush_hold;
   logic             w_load;
   logic [CEW-1:0]   w_cnt_eff;
   logic [ACC_W-1:0] w_acc_next;
   logic [OUT_W-1:0] w_stage;
   logic [OUT_W-1:0] w_load_data;
   logic [PACK_N-1:0] w_load_keep;

   // Accept/ready decision, accumulator update and the word offered to the slot.
   always_comb begin
      w_last      = (r_cnt == LAST);
      w_ready     = !w_flush_pend && (!w_last || w_slot_free);
      w_fire      = hs.valid_pre_i && w_ready;
      w_full      = w_fire && w_last;
      w_cnt_eff   = {1'b0, r_cnt} + CEW'(w_fire);
      w_acc_next  = r_acc;
      for (int k = 0; k < PACK_N-1; k++) begin
         w_acc_next[k*DATA_W +: DATA_W] = (w_fire && (r_cnt == CW'(k))) ?
                                          hs.data_pre_i : r_acc[k*DATA_W +: DATA_W];
      end
      w_stage = {hs.data_pre_i, w_acc_next};
`ifdef PARTIAL_FLUSH_EN
      // A beat taken in the flush cycle joins the partial word; a completing beat makes it a full word.
      w_flush_req = w_flush_pend || (hs.flush_i && !w_full && (w_cnt_eff != CEW'(0)));
`else
      w_flush_req = 1'b0;
`endif
      w_flush_go   = w_flush_req && w_slot_free;
      w_flush_hold = w_flush_req && !w_slot_free;
      w_load       = w_full || w_flush_go;
      w_load_data  = {OUT_W{1'b0}};
      w_load_keep  = {PACK_N{1'b1}};
      if (w_full) begin
         w_load_data = {hs.data_pre_i, r_acc};
         w_load_keep = {PACK_N{1'b1}};
      end else begin
         for (int k = 0; k < PACK_N; k++) begin
            w_load_keep[k] = (CEW'(k) < w_cnt_eff);
            w_load_data[k*DATA_W +: DATA_W] = (CEW'(k) < w_cnt_eff) ?
                                              w_stage[k*DATA_W +: DATA_W] : {DATA_W{1'b0}};
         end
      end
   end

   // Beat counter and accumulator; a reset mid-word discards the partial beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CW{1'b0}};
         r_acc <= {ACC_W{1'b0}};
      end else begin
         if (w_load) begin
            r_cnt <= {CW{1'b0}};
         end else if (w_fire) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         r_acc <= w_acc_next;
      end
   end

`ifdef PARTIAL_FLUSH_EN
   logic r_flush_pend;

   // Remembers a flush that arrived while the slot was stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_pend <= 1'b0;
      end else if (w_flush_go) begin
         r_flush_pend <= 1'b0;
      end else if (w_flush_hold) begin
         r_flush_pend <= 1'b1;
      end else begin
         r_flush_pend <= r_flush_pend;
      end
   end

   assign w_flush_pend = r_flush_pend;
`else
   assign w_flush_pend = 1'b0;
`endif

   assign hs.ready_pre_o = w_ready;

   hs_out_slot #(
      .W  (OUT_W),
      .KW (PACK_N)
   ) u_out_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_data  (w_load_data),
      .i_keep  (w_load_keep),
      .i_ready (hs.ready_post_i),
      .o_valid (hs.valid_post_o),
      .o_data  (hs.data_post_o),
      .o_keep  (hs.keep_post_o),
      .o_free  (w_slot_free)
   );

endmodule
